multicycle_controller: RTL

Multicycle control unit for the 8-bit-data / 12-bit-address datapath. It fetches a two-byte instruction, decodes it and sequences execution over several cycles. It drives the one-hot select lines of the datapath multiplexers (address, accumulator input, PC source), plus register loads, ALU op and memory strobes. Memory accesses use a ready handshake, so wait-state memories are supported.

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/ctrl_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle controller: state encoding, opcodes,
// ALU operation codes and the bundled control-output record.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetchHi = 3'd0,
    StFetchLo = 3'd1,
    StDecode  = 3'd2,
    StExecRd  = 3'd3,
    StExecWr  = 3'd4,
    StHalt    = 3'd5
  } state_t;

  // Opcodes 8-14 are unassigned and execute as NOP.
  typedef enum logic [3:0] {
    OpLda = 4'h0,
    OpSta = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpAnd = 4'h4,
    OpNot = 4'h5,
    OpJmp = 4'h6,
    OpJz  = 4'h7,
    OpHlt = 4'hF
  } opcode_t;

  localparam logic [2:0] AluPass = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluSub  = 3'd2;
  localparam logic [2:0] AluAnd  = 3'd3;
  localparam logic [2:0] AluNot  = 3'd4;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_hi_ld;
    logic       ir_lo_ld;
    logic       pc_ld;
    logic       pc_sel_inc;
    logic       pc_sel_ir;
    logic       adr_sel_pc;
    logic       adr_sel_ir;
    logic       acc_ld;
    logic       acc_sel_mem;
    logic       acc_sel_alu;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_out_t;

  typedef struct packed {
    state_t     next_state;
    logic       pc_ld;
    logic       pc_sel_ir;
    logic       acc_ld;
    logic       acc_sel_alu;
    logic [2:0] alu_op;
  } dec_out_t;

  function automatic logic [2:0] alu_op_for(input logic [3:0] opcode);
    case (opcode)
      OpAdd:   return AluAdd;
      OpSub:   return AluSub;
      OpAnd:   return AluAnd;
      OpNot:   return AluNot;
      default: return AluPass;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of opcode and acc_zero into the next state and the
// outputs asserted during the DECODE cycle.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  output dec_out_t   dec
);

  always_comb begin
    dec            = '0;
    dec.next_state = StFetchHi;
    case (opcode)
      OpLda, OpAdd, OpSub, OpAnd: dec.next_state = StExecRd;
      OpSta:                      dec.next_state = StExecWr;
      OpNot: begin
        dec.acc_ld      = 1'b1;
        dec.acc_sel_alu = 1'b1;
        dec.alu_op      = AluNot;
      end
      OpJmp: begin
        dec.pc_ld     = 1'b1;
        dec.pc_sel_ir = 1'b1;
      end
      OpJz: begin
        dec.pc_ld     = acc_zero;
        dec.pc_sel_ir = acc_zero;
      end
      OpHlt:   dec.next_state = StHalt;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit: two-byte fetch, decode and ready-handshaked execute,
// driving one-hot datapath selects, register loads, ALU op and memory strobes.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ready,
  input  logic        acc_zero,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_hi_ld,
  output logic        ir_lo_ld,
  input  logic [15:0] ir,
  output logic        pc_ld,
  output logic        pc_sel_inc,
  output logic        pc_sel_ir,
  output logic        adr_sel_pc,
  output logic        adr_sel_ir,
  output logic        acc_ld,
  output logic        acc_sel_mem,
  output logic        acc_sel_alu,
  output logic [2:0]  alu_op,
  output logic        halted
);

  state_t    state_q, state_d;
  dec_out_t  dec;
  ctrl_out_t ctl, ctl_gated;
  logic      unused_ir;

  assign unused_ir = ^ir[11:0];

  ctrl_decoder u_decoder (
    .opcode   (ir[15:12]),
    .acc_zero (acc_zero),
    .dec      (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetchHi;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    unique case (state_q)
      StFetchHi, StFetchLo: begin
        ctl.mem_rd     = 1'b1;
        ctl.adr_sel_pc = 1'b1;
        if (mem_ready) begin
          ctl.ir_hi_ld   = (state_q == StFetchHi);
          ctl.ir_lo_ld   = (state_q == StFetchLo);
          ctl.pc_ld      = 1'b1;
          ctl.pc_sel_inc = 1'b1;
          state_d        = (state_q == StFetchHi) ? StFetchLo : StDecode;
        end
      end
      StDecode: begin
        ctl.pc_ld       = dec.pc_ld;
        ctl.pc_sel_ir   = dec.pc_sel_ir;
        ctl.acc_ld      = dec.acc_ld;
        ctl.acc_sel_alu = dec.acc_sel_alu;
        ctl.alu_op      = dec.alu_op;
        state_d         = dec.next_state;
      end
      StExecRd: begin
        ctl.mem_rd     = 1'b1;
        ctl.adr_sel_ir = 1'b1;
        if (mem_ready) begin
          ctl.acc_ld = 1'b1;
          if (ir[15:12] == OpLda) begin
            ctl.acc_sel_mem = 1'b1;
          end else begin
            ctl.acc_sel_alu = 1'b1;
            ctl.alu_op      = alu_op_for(ir[15:12]);
          end
          state_d = StFetchHi;
        end
      end
      StExecWr: begin
        ctl.mem_wr     = 1'b1;
        ctl.adr_sel_ir = 1'b1;
        if (mem_ready) state_d = StFetchHi;
      end
      StHalt:  ctl.halted = 1'b1;
      default: state_d = StFetchHi;
    endcase
  end

  // Reset gates every output combinationally so an in-flight access aborts at once.
  assign ctl_gated = rst_n ? ctl : '0;

  assign mem_rd      = ctl_gated.mem_rd;
  assign mem_wr      = ctl_gated.mem_wr;
  assign ir_hi_ld    = ctl_gated.ir_hi_ld;
  assign ir_lo_ld    = ctl_gated.ir_lo_ld;
  assign pc_ld       = ctl_gated.pc_ld;
  assign pc_sel_inc  = ctl_gated.pc_sel_inc;
  assign pc_sel_ir   = ctl_gated.pc_sel_ir;
  assign adr_sel_pc  = ctl_gated.adr_sel_pc;
  assign adr_sel_ir  = ctl_gated.adr_sel_ir;
  assign acc_ld      = ctl_gated.acc_ld;
  assign acc_sel_mem = ctl_gated.acc_sel_mem;
  assign acc_sel_alu = ctl_gated.acc_sel_alu;
  assign alu_op      = ctl_gated.alu_op;
  assign halted      = ctl_gated.halted;

endmodule
